// File: rtl/button_conditioner_if.sv
// Button bus between the raw switch lines and the conditioner: raw lines in,
// debounced level and one-cycle press pulse out.
interface button_conditioner_if #(
  parameter int NUM_BTN = 7
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_pulse;

  modport master (output btn_raw, input btn_level, btn_pulse);
  modport slave  (input btn_raw, output btn_level, btn_pulse);
endinterface

// File: rtl/button_conditioner.sv
// Button front end: per-line 2-flop sync + counter debounce + registered press pulse.
// Optional auto-repeat on REPEAT_BIT when BTN_AUTO_REPEAT_EN is defined.

module btn_lane #(
  parameter int CNT_W     = 16,
  parameter int DB_CYCLES = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic raw,
  output logic level,
  output logic level_nxt
);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s1_d, s2_q, s2_d, level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d    = raw;
    s2_d    = s1_q;
    level_d = level_q;
    cnt_d   = cnt_q + 1'b1;
    // Any sample agreeing with the accepted level restarts the run.
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      level_d = s2_q;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level     = level_q;
  assign level_nxt = level_d;
endmodule

module button_conditioner #(
  parameter int NUM_BTN       = 7,
  parameter int CNT_W         = 16,
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_BIT    = 1,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  button_conditioner_if.slave  bus
);
  logic [NUM_BTN-1:0] lvl, lvl_nxt, rep_fire;
  logic [NUM_BTN-1:0] pulse_q, pulse_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    btn_lane #(.CNT_W(CNT_W), .DB_CYCLES(DB_CYCLES)) u_lane (
      .Clk       (Clk),
      .Reset     (Reset),
      .raw       (bus.btn_raw[i]),
      .level     (lvl[i]),
      .level_nxt (lvl_nxt[i])
    );
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_FIRST  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_NEXT   = CNT_W'(REPEAT_DELAY + REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY + 1);

  logic [CNT_W-1:0] rc_q, rc_d;

  // rc is 0 during the press-pulse cycle and counts cycles held since then;
  // after the first repeat it cycles RPT_RELOAD..RPT_NEXT to give the period.
  always_comb begin
    rc_d     = rc_q;
    rep_fire = '0;
    if (!lvl[REPEAT_BIT]) begin
      rc_d = '0;
    end else begin
      if ((rc_q == RPT_FIRST || rc_q == RPT_NEXT) && lvl_nxt[REPEAT_BIT])
        rep_fire[REPEAT_BIT] = 1'b1;
      if (rc_q == RPT_NEXT)  rc_d = RPT_RELOAD;
      else if (rc_q != '1)   rc_d = rc_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) rc_q <= '0;
    else        rc_q <= rc_d;
  end
`else
  assign rep_fire = '0;
`endif

  always_comb pulse_d = (lvl_nxt & ~lvl) | rep_fire;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) pulse_q <= '0;
    else        pulse_q <= pulse_d;
  end

  assign bus.btn_level = lvl;
  assign bus.btn_pulse = pulse_q;
endmodule
